// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states and a one-cycle HREADY completion.
// Optional byte-lane write strobes via `define MEM_BYTE_STROBE_EN (adds HBSTRB port).

module mem_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HTRANS,
  input  logic [31:0] PADDR,
  input  logic        HWRITE,
  input  logic [31:0] PDATA,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  HBSTRB,
`endif
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, data_q;
  logic        write_q;
  logic [3:0]  strb_q;

  logic        req, from_bus, op_fire, op_write, op_err;
  logic [31:0] op_addr, op_data, offset;
  logic [3:0]  op_strb, lane_we;
  logic [ADDR_WIDTH-1:0] word;
  logic [3:0][7:0] rd_lane;

  // A floating arbiter bus (X/Z) must never look like a request.
  assign req = (HTRANS === 1'b1);

  // With no wait states the memory access happens on the accepting edge, straight off the bus.
  assign from_bus = (state == IDLE);
  assign op_addr  = from_bus ? PADDR  : addr_q;
  assign op_data  = from_bus ? PDATA  : data_q;
  assign op_write = from_bus ? HWRITE : write_q;
`ifdef MEM_BYTE_STROBE_EN
  assign op_strb  = from_bus ? HBSTRB : strb_q;
`else
  assign op_strb  = 4'hF;
`endif

  assign op_fire = !HRESET &&
                   ((from_bus && req && NO_WAIT) || (state == WAIT && cnt == 4'd1));

  // Offset wraps, so addresses below BASE_ADDR land out of range.
  assign offset = op_addr - BASE_ADDR;
  assign op_err = (offset[1:0] != 2'b00) || ((offset >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word   = offset[ADDR_WIDTH+1:2];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_we[i] = op_fire && op_write && !op_err && op_strb[i];
    mem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk   (HCLK),
      .we    (lane_we[i]),
      .addr  (word),
      .wdata (op_data[8*i +: 8]),
      .rdata (rd_lane[i])
    );
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      HREADY  <= 1'b0;
      HRESP   <= 1'b0;
      HRDATA  <= '0;
    end else begin
      HREADY <= 1'b0;
      HRESP  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          addr_q  <= PADDR;
          data_q  <= PDATA;
          write_q <= HWRITE;
`ifdef MEM_BYTE_STROBE_EN
          strb_q  <= HBSTRB;
`else
          strb_q  <= 4'hF;
`endif
          cnt     <= 4'(WAIT_STATES);
          state   <= NO_WAIT ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // HRDATA only moves on a read completion; writes leave it holding.
      if (op_fire) begin
        HREADY <= 1'b1;
        HRESP  <= op_err;
        if (!op_write) HRDATA <= op_err ? 32'd0 : rd_lane;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1, 3 wait states) driven randomly and checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_mem_responder;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
  } xact_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  bit   done [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] pre_val(input int i);
    case (i)
      0:       return 32'h0000_000A;
      1:       return 32'h0000_000B;
      2:       return 32'hCAFE_0000;
      8:       return 32'hFFFF_FFFF;
      default: return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    endcase
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off >= 32'(4 * (1 << AW)));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic        rst = 1'b1, htrans = 1'b0, hwrite = 1'b0, hready, hresp;
    logic [31:0] paddr = '0, pdata = '0, hrdata;
    logic [3:0]  hbstrb = '0;
    xact_t       q[$];
    int          next_free = 0;
    bit          hold_tr = 1'b0;

    mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .HTRANS (htrans),
      .PADDR  (paddr),
      .HWRITE (hwrite),
      .PDATA  (pdata),
`ifdef MEM_BYTE_STROBE_EN
      .HBSTRB (hbstrb),
`endif
      .HRDATA (hrdata),
      .HREADY (hready),
      .HRESP  (hresp)
    );

    // Model: completions land at a fixed cycle after acceptance; memory effects apply there.
    initial begin : model
      logic [31:0] mem_m [0:1023];
      logic [31:0] sticky;
      xact_t       t;
      bit          exp_rdy, e;
      int          wd;
      sticky = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          sticky = '0;
          check($sformatf("ws%0d_rst_hready", WS), 32'(hready), 32'd0);
          check($sformatf("ws%0d_rst_hrdata", WS), hrdata, 32'd0);
        end else begin
          exp_rdy = (q.size() > 0) && (q[0].due == cyc);
          check($sformatf("ws%0d_hready@%0d", WS, cyc), 32'(hready), 32'(exp_rdy));
          if (exp_rdy) begin
            t  = q.pop_front();
            e  = is_err(t.a);
            wd = int'((t.a - BASE) / 4);
            check($sformatf("ws%0d_hresp@%0d", WS, cyc), 32'(hresp), 32'(e));
            if (!t.w) sticky = e ? 32'd0 : mem_m[wd];
            else if (!e) begin
`ifdef MEM_BYTE_STROBE_EN
              for (int b = 0; b < 4; b++)
                if (t.s[b]) mem_m[wd][8*b +: 8] = t.d[8*b +: 8];
`else
              mem_m[wd] = t.d;
`endif
            end
          end
          check($sformatf("ws%0d_hrdata@%0d", WS, cyc), hrdata, sticky);
        end
      end
    end

    // Off-request cycles carry garbage; HTRANS may only be high while the DUT ignores it.
    task automatic idle_drive();
      paddr  = $urandom;
      pdata  = $urandom;
      hwrite = 1'($urandom);
      hbstrb = 4'($urandom);
      if (cyc + 1 < next_free) htrans = hold_tr ? 1'b1 : 1'($urandom);
      else                     htrans = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input bit hold, output int due);
      while (cyc + 1 < next_free) begin
        idle_drive();
        @(negedge clk);
      end
      paddr = a; hwrite = w; pdata = d; hbstrb = s; htrans = 1'b1;
      due = cyc + 1 + WS;
      q.push_back('{due, a, w, d, s});
      next_free = due + 2;
      hold_tr = hold;
      @(negedge clk);
      idle_drive();
    endtask

    task automatic wait_due(input int due, output logic [31:0] rd, output logic rs);
      while (cyc < due) begin
        @(negedge clk);
        idle_drive();
      end
      check($sformatf("ws%0d_dir_hready", WS), 32'(hready), 32'd1);
      rd = hrdata;
      rs = hresp;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic rs);
      int due;
      req(a, w, d, s, 1'b0, due);
      wait_due(due, rd, rs);
    endtask

    initial begin : drive
      logic [31:0] rd, a;
      logic        rs;
      int          d1, d2, k, wd;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) xfer(32'(i * 4), 1'b1, pre_val(i), 4'hF, rd, rs);

      if (WS == 0) begin
        req(32'h0, 1'b0, '0, 4'hF, 1'b1, d1);
        wait_due(d1, rd, rs);
        check("ws0_b2b_a", rd, 32'h0000_000A);
        req(32'h4, 1'b0, '0, 4'hF, 1'b1, d2);
        wait_due(d2, rd, rs);
        check("ws0_b2b_b", rd, 32'h0000_000B);
        check("ws0_b2b_gap", 32'(d2 - d1), 32'd2);
        hold_tr = 1'b0;
      end else if (WS == 1) begin
        xfer(32'h40, 1'b1, 32'h1234_5678, 4'hF, rd, rs);
        xfer(32'h40, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_rd40", rd, 32'h1234_5678);
        check("ws1_rd40_resp", 32'(rs), 32'd0);
        xfer(32'h42, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_mis_resp", 32'(rs), 32'd1);
        check("ws1_mis_data", rd, 32'd0);
        xfer(32'h1000, 1'b1, 32'h0BAD_0BAD, 4'hF, rd, rs);
        check("ws1_oor_resp", 32'(rs), 32'd1);
        xfer(BASE - 32'd4, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_below_resp", 32'(rs), 32'd1);
        check("ws1_below_data", rd, 32'd0);
        xfer(32'h0, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_word0_kept", rd, 32'h0000_000A);
        xfer(32'h8, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_rd8", rd, 32'hCAFE_0000);
        xfer(32'h8, 1'b1, 32'h1, 4'hF, rd, rs);
        check("ws1_hold", rd, 32'hCAFE_0000);
`ifdef MEM_BYTE_STROBE_EN
        xfer(32'h20, 1'b1, 32'h0, 4'b0101, rd, rs);
        xfer(32'h20, 1'b0, '0, 4'hF, rd, rs);
        check("ws1_strobe", rd, 32'hFF00_FF00);
`endif
      end else begin
        xfer(32'h8, 1'b0, '0, 4'hF, rd, rs);
        check("ws3_rd8", rd, 32'hCAFE_0000);
        req(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, d1);
        @(negedge clk);
        #2 rst = 1'b1; htrans = 1'b0;
        #1;
        check("ws3_async_hready", 32'(hready), 32'd0);
        check("ws3_async_hresp", 32'(hresp), 32'd0);
        check("ws3_async_hrdata", hrdata, 32'd0);
        @(negedge clk);
        next_free = 0;
        hold_tr = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        xfer(32'h10, 1'b0, '0, 4'hF, rd, rs);
        check("ws3_no_commit", rd, pre_val(4));
      end

      for (int n = 0; n < 250; n++) begin
        k  = $urandom_range(0, 9);
        wd = $urandom_range(0, 31);
        case (k)
          7:       a = 32'(wd * 4 + $urandom_range(1, 3));
          8:       a = ($urandom | 32'h0000_1000) & ~32'h3;
          9:       a = 32'hFFFF_FFFC - 32'(wd * 4);
          default: a = 32'(wd * 4);
        endcase
        req(a, 1'($urandom), $urandom, 4'($urandom), 1'($urandom), d1);
      end
      hold_tr = 1'b0;
      while (cyc < next_free + 2) begin
        @(negedge clk);
        idle_drive();
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(done[0] && done[1] && done[2]) && waited < 40000) begin
      @(posedge clk);
      waited++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      n_tot++;
      $display("FAIL timeout: done=%0b%0b%0b, want 111", done[0], done[1], done[2]);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
